bat_amateur_useq: RTL and testbench
===================================

# bat_amateur_useq

Parametrised microcode sequencer for the BatAmateur CPU. It sits between the instruction register, the ALU flag register and the datapath control lines. It steps a micro-op counter, latches a masked subset of ALU flags, and supports conditional micro-branches, bus stalls and a halt state. A decode-ROM sub-module turns {INSTR, uOP, FLAGS} into the flat control word that drives PC, MAR, RAM, IR, register file and ALU.

## Interface
- INSTR_W, 16, instruction word width
- UOP_W, 3, micro-op counter width (2^UOP_W steps per instruction)
- NFLAGS, 2, number of latched ALU flags (bit0 = zero, bit1 = carry-out)
- CTRL_W, 40, width of the datapath control word
- CLK  in  1  clock; all sequencer state updates on the falling edge
- RST  in  1  reset, synchronous, active-low
- INSTR  in  INSTR_W  current instruction from IR
- ALU_FLAGS  in  NFLAGS  flag outputs of the ALU register
- STALL  in  1  datapath/bus wait; holds the current micro-op
- RESUME  in  1  single-cycle pulse that leaves HALTED
- CTRL  out  CTRL_W  datapath control word (PC/MAR/RAM/IR/REGS/ALU fields)
- UOP  out  UOP_W  current micro-op index
- FLAGS  out  NFLAGS  latched flags
- HALTED  out  1  sequencer is in the HALTED state

## Operation
- The ROM returns CTRL plus sequencer fields:
  - END (reset uOP)
  - READ_FLAGS
  - FLAG_MASK[NFLAGS]
  - BR_EN
  - BR_SEL[clog2(NFLAGS)]
  - BR_POL
  - BR_TGT[UOP_W]
  - HALT
- States: RUN, HALTED.
- Per falling edge in RUN, the first matching rule applies:
  1. RST low: UOP = all ones, FLAGS = 0, state = RUN.
  2. STALL: hold UOP and FLAGS.
  3. HALT: enter HALTED and hold UOP.
  4. END: UOP = all ones.
  5. BR_EN and FLAGS[BR_SEL] == BR_POL: UOP = BR_TGT.
  6. Otherwise: UOP = UOP + 1, mod 2^UOP_W, wrapping silently.
- Flag update is independent of rules 3–6 but suppressed by STALL and RST. When READ_FLAGS is set, each FLAGS[i] with FLAG_MASK[i] = 1 loads ALU_FLAGS[i]; unmasked bits hold.
- A branch evaluates the FLAGS register value from before this edge, not a value being loaded in the same step.
- HALTED:
  - UOP and FLAGS are frozen; STALL is ignored.
  - RESUME on a falling edge returns to RUN with UOP = all ones, so the next edge fetches at step 0.
  - RST overrides RESUME.
- CTRL is forced to zero while RST is low or while HALTED. Otherwise CTRL is the ROM output.
- Reset values: UOP = all ones, FLAGS = 0, HALTED = 0, CTRL = 0.
- The first falling edge after RST rises moves UOP to 0, the first fetch step.
- Unused ROM entries decode to END = 1 with CTRL = 0, giving safe recovery from illegal opcodes.

## Timing
- State changes on the falling edge of CLK. CTRL, UOP and FLAGS are stable by the next rising edge, where the datapath registers sample.
- CTRL is combinational from {INSTR, UOP, FLAGS, state, RST}. There is zero cycles of latency from a UOP change to CTRL.
- STALL, RESUME and ALU_FLAGS are sampled on the falling edge only. They must be valid before it.
- Latencies:
  - A branch costs no extra cycle: the target is executing one full cycle after the branching step.
  - READ_FLAGS in step n makes the new FLAGS visible to a branch in step n+1.
  - A STALL held for k falling edges extends the step by exactly k cycles.
- If HALT and END are both set, HALT wins.
- If STALL and HALT are both set, STALL wins, and the halt is taken on the first unstalled edge.
- RST mid-instruction aborts immediately on that edge. No partial flag update occurs.

## Structure
- Shared package bat_amateur_pkg holds:
  - the CTRL field offsets and widths (PC/MAR/RAM/IR/REGS/ALU_OP);
  - the sequencer-field offsets;
  - the state enum {RUN, HALTED};
  - the constant UOP_START = all ones;
  - the flag indices FLAG_ZERO = 0 and FLAG_COUT = 1.
- Sub-module bat_amateur_uop_rom: combinational decode of {INSTR opcode, UOP, FLAGS} into CTRL plus the sequencer fields, parameterised on INSTR_W, UOP_W, NFLAGS and CTRL_W.
- The top level contains only the FSM, the counter, the flag register and the CTRL gating.

## Test plan
- Reset: hold RST low for 3 cycles, then release.
  - During reset: UOP = 7, FLAGS = 0, CTRL = 0.
  - First falling edge after release: UOP = 0, with the fetch CTRL (PC_EN, MAR_LOAD) asserted.
- Straight-line instruction with END at step 4: UOP sequence 0,1,2,3,4,7,0. Wrap check: a ROM entry without END at step 7 goes 7→0.
- Flags: READ_FLAGS with mask 2'b01 and ALU_FLAGS = 2'b11 gives FLAGS = 2'b01. A following branch on carry with BR_POL = 1 is not taken (UOP increments). A branch on zero with BR_TGT = 6 is taken (UOP = 6 next).
- STALL high for 3 edges at UOP = 2, with READ_FLAGS set: UOP stays 2 and FLAGS are unchanged. After release the flags load and UOP moves to 3.
- HALT at step 3:
  - HALTED = 1, CTRL = 0, and UOP holds 3 for 10 cycles, including while STALL toggles.
  - A RESUME pulse gives HALTED = 0 and UOP = 7, then 0.
  - Repeat with RST low asserted in the same cycle as RESUME: the reset values result.
- Illegal opcode 16'hFFFF: CTRL = 0 with END at step 0, so UOP cycles 0,7,0 and no datapath enable is ever asserted.

Source files
------------

// File: rtl/bat_amateur_pkg.sv
// bat_amateur_pkg
// Shared definitions for the BatAmateur microcode sequencer:
//   - datapath control-word field offsets/widths (PC, MAR, RAM, IR, REGS, ALU)
//   - sequencer-field offsets inside the ROM's sequencer word
//   - sequencer state enum, UOP_START, flag indices and the opcode map
package bat_amateur_pkg;

    // Datapath control word layout
    localparam int CTRL_PC_OFF   = 0;
    localparam int CTRL_PC_W     = 4;
    localparam int CTRL_MAR_OFF  = 4;
    localparam int CTRL_MAR_W    = 2;
    localparam int CTRL_RAM_OFF  = 6;
    localparam int CTRL_RAM_W    = 4;
    localparam int CTRL_IR_OFF   = 10;
    localparam int CTRL_IR_W     = 2;
    localparam int CTRL_REGS_OFF = 12;
    localparam int CTRL_REGS_W   = 16;
    localparam int CTRL_ALU_OFF  = 28;
    localparam int CTRL_ALU_W    = 12;

    // Individual control lines
    localparam int PC_EN     = CTRL_PC_OFF + 0;    // PC drives the address bus
    localparam int PC_INC    = CTRL_PC_OFF + 1;
    localparam int MAR_LOAD  = CTRL_MAR_OFF + 0;
    localparam int RAM_OE    = CTRL_RAM_OFF + 0;
    localparam int IR_LOAD   = CTRL_IR_OFF + 0;
    localparam int OPER_W    = 12;                 // register selects copied from INSTR[11:0]
    localparam int REG_WE    = CTRL_REGS_OFF + OPER_W;
    localparam int REG_OE    = CTRL_REGS_OFF + OPER_W + 1;
    localparam int ALU_CIN   = CTRL_ALU_OFF + 4;
    localparam int ALU_LATCH = CTRL_ALU_OFF + 5;   // latch result and ALU flags

    // Sequencer word layout: single-bit fields first, then mask, select, target
    localparam int SEQ_END        = 0;
    localparam int SEQ_READ_FLAGS = 1;
    localparam int SEQ_BR_EN      = 2;
    localparam int SEQ_BR_POL     = 3;
    localparam int SEQ_HALT       = 4;
    localparam int SEQ_MASK_OFF   = 5;

    function automatic int sel_width(input int nflags);
        return (nflags > 1) ? $clog2(nflags) : 1;
    endfunction

    function automatic int seq_sel_off(input int nflags);
        return SEQ_MASK_OFF + nflags;
    endfunction

    function automatic int seq_tgt_off(input int nflags);
        return seq_sel_off(nflags) + sel_width(nflags);
    endfunction

    function automatic int seq_width(input int nflags, input int uop_w);
        return seq_tgt_off(nflags) + uop_w;
    endfunction

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    // Truncated to UOP_W where used
    localparam logic [31:0] UOP_START = '1;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_COUT = 1;

    localparam int OPCODE_W = 4;
    typedef enum logic [OPCODE_W-1:0] {
        OP_ALU    = 4'h0,   // fetch, read regs, ALU, write back, END at step 4
        OP_LOOP   = 4'h1,   // long no-op, never ENDs: counter wraps 7 -> 0
        OP_BRANCH = 4'h2,   // load zero flag, branch on carry, branch on zero
        OP_LDFLAG = 4'h3,   // load all flags at step 2, END at step 3
        OP_HALT   = 4'h4    // HALT (with END) at step 3
    } opcode_e;

endpackage

// File: rtl/bat_amateur_uop_rom.sv
// bat_amateur_uop_rom
// Combinational decode of {opcode, uop, flags} into the datapath control word
// and the sequencer word.
//   instr : current instruction (opcode in the top OPCODE_W bits)
//   uop   : current micro-op index
//   flags : latched ALU flags
//   ctrl  : datapath control word
//   seq   : {BR_TGT, BR_SEL, FLAG_MASK, HALT, BR_POL, BR_EN, READ_FLAGS, END}
module bat_amateur_uop_rom
    import bat_amateur_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int UOP_W   = 3,
    parameter int NFLAGS  = 2,
    parameter int CTRL_W  = 40
) (
    input  logic [INSTR_W-1:0]                    instr,
    input  logic [UOP_W-1:0]                      uop,
    input  logic [NFLAGS-1:0]                     flags,
    output logic [CTRL_W-1:0]                     ctrl,
    output logic [seq_width(NFLAGS, UOP_W)-1:0]   seq
);

    localparam int SEL_W = sel_width(NFLAGS);

    logic [OPCODE_W-1:0] opc;
    logic                end_f, rd_f, br_en_f, br_pol_f, halt_f;
    logic [NFLAGS-1:0]   mask_f;
    logic [SEL_W-1:0]    br_sel_f;
    logic [UOP_W-1:0]    br_tgt_f;

    assign opc = instr[INSTR_W-1 -: OPCODE_W];

    always_comb begin
        // Everything not decoded below is an unused entry: END with CTRL = 0
        ctrl     = '0;
        end_f    = 1'b1;
        rd_f     = 1'b0;
        mask_f   = '0;
        br_en_f  = 1'b0;
        br_pol_f = 1'b0;
        br_sel_f = '0;
        br_tgt_f = '0;
        halt_f   = 1'b0;

        if (uop == '1) begin
            // The all-ones slot is the idle step between instructions for every
            // opcode (legal or not); it never ENDs so the next edge fetches at 0.
            end_f = 1'b0;
        end else if (opc <= OP_HALT) begin
            if (uop == UOP_W'(0)) begin
                end_f          = 1'b0;
                ctrl[PC_EN]    = 1'b1;
                ctrl[MAR_LOAD] = 1'b1;
            end else if (uop == UOP_W'(1)) begin
                end_f         = 1'b0;
                ctrl[RAM_OE]  = 1'b1;
                ctrl[IR_LOAD] = 1'b1;
                ctrl[PC_INC]  = 1'b1;
            end else begin
                case (opc)
                    OP_ALU: begin
                        if (uop == UOP_W'(2)) begin
                            end_f = 1'b0;
                            ctrl[CTRL_REGS_OFF +: OPER_W] = instr[OPER_W-1:0];
                            ctrl[REG_OE] = 1'b1;
                        end else if (uop == UOP_W'(3)) begin
                            end_f = 1'b0;
                            ctrl[CTRL_REGS_OFF +: OPER_W] = instr[OPER_W-1:0];
                            ctrl[ALU_LATCH] = 1'b1;
                            ctrl[ALU_CIN]   = flags[FLAG_COUT];
                        end else if (uop == UOP_W'(4)) begin
                            ctrl[CTRL_REGS_OFF +: OPER_W] = instr[OPER_W-1:0];
                            ctrl[REG_WE] = 1'b1;
                        end
                    end
                    OP_LOOP: begin
                        end_f = 1'b0;
                    end
                    OP_BRANCH: begin
                        if (uop == UOP_W'(2)) begin
                            end_f             = 1'b0;
                            ctrl[ALU_LATCH]   = 1'b1;
                            rd_f              = 1'b1;
                            mask_f[FLAG_ZERO] = 1'b1;
                        end else if (uop == UOP_W'(3)) begin
                            end_f    = 1'b0;
                            br_en_f  = 1'b1;
                            br_sel_f = SEL_W'(FLAG_COUT);
                            br_pol_f = 1'b1;
                            br_tgt_f = UOP_W'(5);
                        end else if (uop == UOP_W'(4)) begin
                            end_f    = 1'b0;
                            br_en_f  = 1'b1;
                            br_sel_f = SEL_W'(FLAG_ZERO);
                            br_pol_f = 1'b1;
                            br_tgt_f = UOP_W'(6);
                        end else if (uop == UOP_W'(6)) begin
                            // Conditional write-back: only when the result was zero
                            ctrl[REG_WE] = flags[FLAG_ZERO];
                        end
                    end
                    OP_LDFLAG: begin
                        if (uop == UOP_W'(2)) begin
                            end_f           = 1'b0;
                            ctrl[ALU_LATCH] = 1'b1;
                            rd_f            = 1'b1;
                            mask_f          = '1;
                        end
                    end
                    OP_HALT: begin
                        if (uop == UOP_W'(2)) begin
                            end_f = 1'b0;
                        end else if (uop == UOP_W'(3)) begin
                            halt_f = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign seq = {br_tgt_f, br_sel_f, mask_f, halt_f, br_pol_f, br_en_f, rd_f, end_f};

endmodule

// File: rtl/bat_amateur_useq.sv
// bat_amateur_useq
// Microcode sequencer: micro-op counter, masked flag register, conditional
// micro-branches, bus stalls and a HALTED state. State moves on the falling
// edge of CLK so outputs settle before the datapath samples on the rising edge.
//   CLK       : clock (sequencer acts on falling edge)
//   RST       : synchronous active-low reset
//   INSTR     : instruction from IR
//   ALU_FLAGS : ALU flag outputs (bit0 zero, bit1 carry-out)
//   STALL     : holds the current micro-op and flags
//   RESUME    : leaves HALTED
//   CTRL      : datapath control word (zero in reset or HALTED)
//   UOP       : current micro-op index
//   FLAGS     : latched flags
//   HALTED    : sequencer is halted
module bat_amateur_useq
    import bat_amateur_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int UOP_W   = 3,
    parameter int NFLAGS  = 2,
    parameter int CTRL_W  = 40
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [INSTR_W-1:0] INSTR,
    input  logic [NFLAGS-1:0]  ALU_FLAGS,
    input  logic               STALL,
    input  logic               RESUME,
    output logic [CTRL_W-1:0]  CTRL,
    output logic [UOP_W-1:0]   UOP,
    output logic [NFLAGS-1:0]  FLAGS,
    output logic               HALTED
);

    localparam int SEL_W   = sel_width(NFLAGS);
    localparam int SEL_OFF = seq_sel_off(NFLAGS);
    localparam int TGT_OFF = seq_tgt_off(NFLAGS);
    localparam int SEQ_W   = seq_width(NFLAGS, UOP_W);
    localparam logic [UOP_W-1:0] UOP_IDLE = UOP_START[UOP_W-1:0];

    logic [UOP_W-1:0]  uop_q, uop_d;
    logic [NFLAGS-1:0] flags_q, flags_d;
    state_e            state_q, state_d;

    logic [CTRL_W-1:0] rom_ctrl;
    logic [SEQ_W-1:0]  rom_seq;

    bat_amateur_uop_rom #(
        .INSTR_W (INSTR_W),
        .UOP_W   (UOP_W),
        .NFLAGS  (NFLAGS),
        .CTRL_W  (CTRL_W)
    ) u_rom (
        .instr (INSTR),
        .uop   (uop_q),
        .flags (flags_q),
        .ctrl  (rom_ctrl),
        .seq   (rom_seq)
    );

    logic              seq_end, seq_rd, seq_br_en, seq_br_pol, seq_halt;
    logic [NFLAGS-1:0] seq_mask;
    logic [SEL_W-1:0]  seq_sel;
    logic [UOP_W-1:0]  seq_tgt;

    assign seq_end    = rom_seq[SEQ_END];
    assign seq_rd     = rom_seq[SEQ_READ_FLAGS];
    assign seq_br_en  = rom_seq[SEQ_BR_EN];
    assign seq_br_pol = rom_seq[SEQ_BR_POL];
    assign seq_halt   = rom_seq[SEQ_HALT];
    assign seq_mask   = rom_seq[SEQ_MASK_OFF +: NFLAGS];
    assign seq_sel    = rom_seq[SEL_OFF +: SEL_W];
    assign seq_tgt    = rom_seq[TGT_OFF +: UOP_W];

    always_comb begin
        uop_d   = uop_q;
        flags_d = flags_q;
        state_d = state_q;
        if (!RST) begin
            uop_d   = UOP_IDLE;
            flags_d = '0;
            state_d = ST_RUN;
        end else if (state_q == ST_HALTED) begin
            if (RESUME) begin
                state_d = ST_RUN;
                uop_d   = UOP_IDLE;
            end
        end else if (!STALL) begin
            // Branch tests flags_q, i.e. the value before any load on this edge
            if (seq_halt) begin
                state_d = ST_HALTED;
            end else if (seq_end) begin
                uop_d = UOP_IDLE;
            end else if (seq_br_en && (flags_q[seq_sel] == seq_br_pol)) begin
                uop_d = seq_tgt;
            end else begin
                uop_d = uop_q + UOP_W'(1);
            end
            if (seq_rd) begin
                flags_d = (flags_q & ~seq_mask) | (ALU_FLAGS & seq_mask);
            end
        end
    end

    always_ff @(negedge CLK) begin
        uop_q   <= uop_d;
        flags_q <= flags_d;
        state_q <= state_d;
    end

    assign CTRL   = (!RST || state_q == ST_HALTED) ? '0 : rom_ctrl;
    assign UOP    = uop_q;
    assign FLAGS  = flags_q;
    assign HALTED = (state_q == ST_HALTED);

endmodule

// File: tb/tb_bat_amateur_useq.sv
// tb_bat_amateur_useq
// Directed-vector bench for bat_amateur_useq. Inputs change just after the
// rising edge; outputs are sampled 1 time unit after the rising edge that
// follows each falling (active) edge.
module tb_bat_amateur_useq;

    localparam int INSTR_W = 16;
    localparam int UOP_W   = 3;
    localparam int NFLAGS  = 2;
    localparam int CTRL_W  = 40;

    // Hand-computed control words for INSTR = 16'h0123
    localparam logic [63:0] CW_FETCH = 64'h00_0000_0011;  // PC_EN | MAR_LOAD
    localparam logic [63:0] CW_DECODE = 64'h00_0000_0442; // RAM_OE | IR_LOAD | PC_INC
    localparam logic [63:0] CW_RDREG = 64'h00_0212_3000;  // REG_OE | operands 0x123
    localparam logic [63:0] CW_ALU = 64'h02_0012_3000;    // ALU_LATCH | operands, cin=0
    localparam logic [63:0] CW_WB = 64'h00_0112_3000;     // REG_WE | operands
    localparam logic [63:0] CW_CONDWB = 64'h00_0100_0000; // REG_WE only

    logic               CLK = 1'b1;
    logic               RST;
    logic [INSTR_W-1:0] INSTR;
    logic [NFLAGS-1:0]  ALU_FLAGS;
    logic               STALL;
    logic               RESUME;
    logic [CTRL_W-1:0]  CTRL;
    logic [UOP_W-1:0]   UOP;
    logic [NFLAGS-1:0]  FLAGS;
    logic               HALTED;

    int n_total = 0;
    int n_bad   = 0;

    always #5 CLK = ~CLK;

    bat_amateur_useq #(
        .INSTR_W (INSTR_W),
        .UOP_W   (UOP_W),
        .NFLAGS  (NFLAGS),
        .CTRL_W  (CTRL_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .INSTR     (INSTR),
        .ALU_FLAGS (ALU_FLAGS),
        .STALL     (STALL),
        .RESUME    (RESUME),
        .CTRL      (CTRL),
        .UOP       (UOP),
        .FLAGS     (FLAGS),
        .HALTED    (HALTED)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        @(posedge CLK);
        #1;
        $display("t=%0t instr=%h rst=%b stall=%b resume=%b uop=%0d flags=%b halted=%b ctrl=%h",
                 $time, INSTR, RST, STALL, RESUME, UOP, FLAGS, HALTED, CTRL);
    endtask

    initial begin
        RST       = 1'b0;
        INSTR     = 16'h0123;
        ALU_FLAGS = 2'b00;
        STALL     = 1'b0;
        RESUME    = 1'b0;

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) tick();
        chk("rst_uop", 64'(UOP), 64'd7);
        chk("rst_flags", 64'(FLAGS), 64'd0);
        chk("rst_ctrl", 64'(CTRL), 64'd0);
        chk("rst_halted", 64'(HALTED), 64'd0);

        // Straight-line ALU instruction, END at step 4
        RST = 1'b1;
        tick(); chk("alu_u0", 64'(UOP), 64'd0); chk("alu_c0", 64'(CTRL), CW_FETCH);
        tick(); chk("alu_u1", 64'(UOP), 64'd1); chk("alu_c1", 64'(CTRL), CW_DECODE);
        tick(); chk("alu_u2", 64'(UOP), 64'd2); chk("alu_c2", 64'(CTRL), CW_RDREG);
        tick(); chk("alu_u3", 64'(UOP), 64'd3); chk("alu_c3", 64'(CTRL), CW_ALU);
        tick(); chk("alu_u4", 64'(UOP), 64'd4); chk("alu_c4", 64'(CTRL), CW_WB);
        tick(); chk("alu_u7", 64'(UOP), 64'd7); chk("alu_c7", 64'(CTRL), 64'd0);
        tick(); chk("alu_u0b", 64'(UOP), 64'd0);

        // No END anywhere: counter runs 1..7 then wraps to 0
        INSTR = 16'h1000;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("wrap_uop", 64'(UOP), 64'(i % 8));
        end

        // Flag load with mask 01, then branch on carry (not taken), branch on zero (taken)
        INSTR     = 16'h2000;
        ALU_FLAGS = 2'b11;
        tick(); tick();
        chk("br_u2", 64'(UOP), 64'd2);
        tick();
        chk("br_u3", 64'(UOP), 64'd3);
        chk("br_flags", 64'(FLAGS), 64'b01);
        tick();
        chk("br_carry_nt", 64'(UOP), 64'd4);
        tick();
        chk("br_zero_t", 64'(UOP), 64'd6);
        chk("br_condwb", 64'(CTRL), CW_CONDWB);
        tick(); chk("br_u7", 64'(UOP), 64'd7);
        tick(); chk("br_u0", 64'(UOP), 64'd0);

        // Stall at step 2 with READ_FLAGS pending
        INSTR     = 16'h3000;
        ALU_FLAGS = 2'b10;
        tick(); tick();
        chk("st_u2", 64'(UOP), 64'd2);
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_hold_uop", 64'(UOP), 64'd2);
            chk("st_hold_flags", 64'(FLAGS), 64'b01);
        end
        STALL = 1'b0;
        tick();
        chk("st_rel_uop", 64'(UOP), 64'd3);
        chk("st_rel_flags", 64'(FLAGS), 64'b10);
        tick(); chk("st_u7", 64'(UOP), 64'd7);
        tick(); chk("st_u0", 64'(UOP), 64'd0);

        // HALT at step 3, frozen for 10 cycles while STALL toggles, then RESUME
        INSTR = 16'h4000;
        tick(); tick(); tick();
        chk("h_u3", 64'(UOP), 64'd3);
        chk("h_not_yet", 64'(HALTED), 64'd0);
        for (int i = 0; i < 10; i++) begin
            STALL = (i % 2 == 1);
            tick();
            chk("h_halted", 64'(HALTED), 64'd1);
            chk("h_uop", 64'(UOP), 64'd3);
            chk("h_ctrl", 64'(CTRL), 64'd0);
            chk("h_flags", 64'(FLAGS), 64'b10);
        end
        STALL  = 1'b0;
        RESUME = 1'b1;
        tick();
        RESUME = 1'b0;
        chk("res_halted", 64'(HALTED), 64'd0);
        chk("res_uop", 64'(UOP), 64'd7);
        tick();
        chk("res_u0", 64'(UOP), 64'd0);
        chk("res_c0", 64'(CTRL), CW_FETCH);

        // Halt again; RST low together with RESUME gives reset values
        tick(); tick(); tick(); tick();
        chk("h2_halted", 64'(HALTED), 64'd1);
        RESUME = 1'b1;
        RST    = 1'b0;
        tick();
        chk("rr_uop", 64'(UOP), 64'd7);
        chk("rr_flags", 64'(FLAGS), 64'd0);
        chk("rr_halted", 64'(HALTED), 64'd0);
        chk("rr_ctrl", 64'(CTRL), 64'd0);
        RESUME = 1'b0;
        RST    = 1'b1;

        // Illegal opcode: END at step 0 with CTRL = 0
        INSTR = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ill_uop", 64'(UOP), (i % 2 == 0) ? 64'd0 : 64'd7);
            chk("ill_ctrl", 64'(CTRL), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
